// File: rtl/ysyx_22041211_mem_arbiter.sv
// ysyx_22041211_mem_arbiter
//   Shares the single SRAM request/response port between the IFU (read-only)
//   and the LSU (read/write). One transaction is in flight at a time:
//   IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Ports
//   clk, rst              clock; synchronous active-low reset
//   ifu_req_*/ifu_addr_i  IFU fetch request (valid/ready)
//   ifu_resp_*/ifu_rdata  IFU fetch response (valid/ready)
//   lsu_req_*/lsu_addr_i/lsu_wen_i/lsu_wdata_i/lsu_wmask_i
//                         LSU load/store request (valid/ready)
//   lsu_resp_*/lsu_rdata  LSU response; rdata is 0 on a store ack
//   mem_req_*/mem_addr_o/mem_wdata_o/mem_wen_o/mem_wmask_o
//                         request channel to the SRAM wrapper
//   mem_resp_*/mem_rdata_i response channel from the SRAM wrapper
//   grant_o               01 = IFU owns the port, 10 = LSU, 00 = idle
//
// Configuration
//   ARB_ROUND_ROBIN_EN    when defined, a tie goes to the master not granted
//                         last (1-bit history, resets to IFU so the LSU wins
//                         the first tie). Undefined: fixed LSU-over-IFU.

module ysyx_22041211_mem_arbiter #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid_i,
    output logic                ifu_req_ready_o,
    input  logic [ADDR_LEN-1:0] ifu_addr_i,
    output logic                ifu_resp_valid_o,
    input  logic                ifu_resp_ready_i,
    output logic [DATA_LEN-1:0] ifu_rdata_o,
    input  logic                lsu_req_valid_i,
    output logic                lsu_req_ready_o,
    input  logic [ADDR_LEN-1:0] lsu_addr_i,
    input  logic                lsu_wen_i,
    input  logic [DATA_LEN-1:0] lsu_wdata_i,
    input  logic [7:0]          lsu_wmask_i,
    output logic                lsu_resp_valid_o,
    input  logic                lsu_resp_ready_i,
    output logic [DATA_LEN-1:0] lsu_rdata_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_LEN-1:0] mem_addr_o,
    output logic [DATA_LEN-1:0] mem_wdata_o,
    output logic                mem_wen_o,
    output logic [7:0]          mem_wmask_o,
    input  logic                mem_resp_valid_i,
    output logic                mem_resp_ready_o,
    input  logic [DATA_LEN-1:0] mem_rdata_i,
    output logic [1:0]          grant_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_IFU  = 2'b01;
    localparam logic [1:0] GRANT_LSU  = 2'b10;

    // An IFU fetch always reads one full 32-bit instruction word.
    localparam logic [7:0] IFU_WMASK = 8'h0F;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [1:0]          grant_r;
    logic [ADDR_LEN-1:0] addr_r;
    logic [DATA_LEN-1:0] wdata_r;
    logic                wen_r;
    logic [7:0]          wmask_r;
    logic [DATA_LEN-1:0] rdata_r;

    logic                ifu_pick_s;
    logic                lsu_pick_s;
    logic                ifu_hs_s;
    logic                lsu_hs_s;
    logic                resp_hs_s;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = LSU was granted most recently, 0 = IFU (reset value).
    logic                last_lsu_r;
`endif

    // Arbitration between the two masters' raw valids.
    always_comb begin
        ifu_pick_s = 1'b0;
        lsu_pick_s = 1'b0;
        if (ifu_req_valid_i && lsu_req_valid_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            lsu_pick_s = ~last_lsu_r;
            ifu_pick_s = last_lsu_r;
`else
            lsu_pick_s = 1'b1;
            ifu_pick_s = 1'b0;
`endif
        end else begin
            ifu_pick_s = ifu_req_valid_i;
            lsu_pick_s = lsu_req_valid_i;
        end
    end

    // Request handshakes only in IDLE and never while reset is asserted, so
    // ready stays low during reset even if a master holds valid high.
    assign ifu_hs_s = ifu_pick_s && (state_r == ST_IDLE) && rst;
    assign lsu_hs_s = lsu_pick_s && (state_r == ST_IDLE) && rst;

    // Response handshake with whichever master owns the current transaction.
    always_comb begin
        resp_hs_s = 1'b0;
        case (grant_r)
            GRANT_IFU: resp_hs_s = ifu_resp_ready_i;
            GRANT_LSU: resp_hs_s = lsu_resp_ready_i;
            default:   resp_hs_s = 1'b0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ifu_hs_s || lsu_hs_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready_i) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid_i) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (resp_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Transaction capture: request fields on accept, read data on response,
    // grant cleared when the owner takes its response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_r <= GRANT_NONE;
            addr_r  <= {ADDR_LEN{1'b0}};
            wdata_r <= {DATA_LEN{1'b0}};
            wen_r   <= 1'b0;
            wmask_r <= 8'h00;
            rdata_r <= {DATA_LEN{1'b0}};
        end else if (lsu_hs_s) begin
            grant_r <= GRANT_LSU;
            addr_r  <= lsu_addr_i;
            wdata_r <= lsu_wdata_i;
            wen_r   <= lsu_wen_i;
            wmask_r <= lsu_wmask_i;
        end else if (ifu_hs_s) begin
            grant_r <= GRANT_IFU;
            addr_r  <= ifu_addr_i;
            wdata_r <= {DATA_LEN{1'b0}};
            wen_r   <= 1'b0;
            wmask_r <= IFU_WMASK;
        end else if ((state_r == ST_WAIT) && mem_resp_valid_i) begin
            // A store acknowledges with zero data regardless of the bus.
            rdata_r <= wen_r ? {DATA_LEN{1'b0}} : mem_rdata_i;
        end else if ((state_r == ST_RESP) && resp_hs_s) begin
            grant_r <= GRANT_NONE;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember which master was granted last, for tie breaking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_lsu_r <= 1'b0;
        end else if (lsu_hs_s || ifu_hs_s) begin
            last_lsu_r <= lsu_hs_s;
        end else begin
            last_lsu_r <= last_lsu_r;
        end
    end
`endif

    // Output decode from the registered state and captured fields.
    always_comb begin
        ifu_req_ready_o  = ifu_hs_s;
        lsu_req_ready_o  = lsu_hs_s;
        mem_req_valid_o  = (state_r == ST_ISSUE);
        mem_resp_ready_o = (state_r == ST_WAIT);
        ifu_resp_valid_o = (state_r == ST_RESP) && (grant_r == GRANT_IFU);
        lsu_resp_valid_o = (state_r == ST_RESP) && (grant_r == GRANT_LSU);
        mem_addr_o       = addr_r;
        mem_wdata_o      = wdata_r;
        mem_wen_o        = wen_r;
        mem_wmask_o      = wmask_r;
        ifu_rdata_o      = rdata_r;
        lsu_rdata_o      = rdata_r;
        grant_o          = grant_r;
    end

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
module tb_ysyx_22041211_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid_i;
    logic        ifu_req_ready_o;
    logic [31:0] ifu_addr_i;
    logic        ifu_resp_valid_o;
    logic        ifu_resp_ready_i;
    logic [31:0] ifu_rdata_o;
    logic        lsu_req_valid_i;
    logic        lsu_req_ready_o;
    logic [31:0] lsu_addr_i;
    logic        lsu_wen_i;
    logic [31:0] lsu_wdata_i;
    logic [7:0]  lsu_wmask_i;
    logic        lsu_resp_valid_o;
    logic        lsu_resp_ready_i;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_wen_o;
    logic [7:0]  mem_wmask_o;
    logic        mem_resp_valid_i;
    logic        mem_resp_ready_o;
    logic [31:0] mem_rdata_i;
    logic [1:0]  grant_o;

    typedef struct {
        logic [1:0]  grant;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [7:0]  wmask;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   checks_cnt   = 0;
    int   failures_cnt = 0;

    ysyx_22041211_mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .ifu_req_valid_i  (ifu_req_valid_i),
        .ifu_req_ready_o  (ifu_req_ready_o),
        .ifu_addr_i       (ifu_addr_i),
        .ifu_resp_valid_o (ifu_resp_valid_o),
        .ifu_resp_ready_i (ifu_resp_ready_i),
        .ifu_rdata_o      (ifu_rdata_o),
        .lsu_req_valid_i  (lsu_req_valid_i),
        .lsu_req_ready_o  (lsu_req_ready_o),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_wen_i        (lsu_wen_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .lsu_wmask_i      (lsu_wmask_i),
        .lsu_resp_valid_o (lsu_resp_valid_o),
        .lsu_resp_ready_i (lsu_resp_ready_i),
        .lsu_rdata_o      (lsu_rdata_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_wen_o        (mem_wen_o),
        .mem_wmask_o      (mem_wmask_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_ready_o (mem_resp_ready_o),
        .mem_rdata_i      (mem_rdata_i),
        .grant_o          (grant_o)
    );

    // Free-running clock, rising edge active.
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            failures_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Present a request from one or both masters at a falling edge, check
    // which one sees ready, record the expected transaction, then drop valids.
    task automatic drive_req(input logic ifu_v, input logic lsu_v, input logic [1:0] win,
                             input logic [31:0] iaddr, input logic [31:0] laddr,
                             input logic lwen, input logic [31:0] lwdata,
                             input logic [7:0] lmask, input logic [31:0] exp_rdata);
        exp_t e;
        ifu_req_valid_i = ifu_v;
        ifu_addr_i      = iaddr;
        lsu_req_valid_i = lsu_v;
        lsu_addr_i      = laddr;
        lsu_wen_i       = lwen;
        lsu_wdata_i     = lwdata;
        lsu_wmask_i     = lmask;
        #1;
        check_val("ifu_req_ready", {63'd0, ifu_req_ready_o}, {63'd0, (win == 2'b01)});
        check_val("lsu_req_ready", {63'd0, lsu_req_ready_o}, {63'd0, (win == 2'b10)});
        e.grant = win;
        e.addr  = (win == 2'b01) ? iaddr : laddr;
        e.wen   = (win == 2'b01) ? 1'b0 : lwen;
        e.wdata = lwdata;
        e.wmask = lmask;
        e.rdata = exp_rdata;
        sb_q.push_back(e);
        @(negedge clk);
        ifu_req_valid_i = 1'b0;
        lsu_req_valid_i = 1'b0;
    endtask

    // Play the SRAM for the oldest expected transaction and check the
    // response on the owning master. Called at the first ISSUE falling edge.
    task automatic mem_serve(input int rdy_delay, input logic [31:0] mdata, input int hold);
        exp_t e;
        int   wait_cnt;
        logic own_v;
        logic oth_v;
        logic [31:0] own_d;
        if (sb_q.size() == 0) begin
            check_val("sb_nonempty", 64'd0, 64'd1);
            return;
        end
        e = sb_q.pop_front();
        wait_cnt = 0;
        while (mem_req_valid_o !== 1'b1 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check_val("issue_wait", wait_cnt, 0);
        check_val("grant", {62'd0, grant_o}, {62'd0, e.grant});
        check_val("mem_addr", {32'd0, mem_addr_o}, {32'd0, e.addr});
        check_val("mem_wen", {63'd0, mem_wen_o}, {63'd0, e.wen});
        if (e.grant == 2'b10) begin
            check_val("mem_wdata", {32'd0, mem_wdata_o}, {32'd0, e.wdata});
            check_val("mem_wmask", {56'd0, mem_wmask_o}, {56'd0, e.wmask});
        end
        check_val("issue_ifu_rdy", {63'd0, ifu_req_ready_o}, 64'd0);
        check_val("issue_resp_rdy", {63'd0, mem_resp_ready_o}, 64'd0);
        for (int i = 0; i < rdy_delay; i++) begin
            @(negedge clk);
            check_val("stall_valid", {63'd0, mem_req_valid_o}, 64'd1);
            check_val("stall_addr", {32'd0, mem_addr_o}, {32'd0, e.addr});
            check_val("stall_wen", {63'd0, mem_wen_o}, {63'd0, e.wen});
        end
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        check_val("wait_req_valid", {63'd0, mem_req_valid_o}, 64'd0);
        check_val("wait_resp_rdy", {63'd0, mem_resp_ready_o}, 64'd1);
        mem_resp_valid_i = 1'b1;
        mem_rdata_i      = mdata;
        @(negedge clk);
        mem_resp_valid_i = 1'b0;
        mem_rdata_i      = 32'hA5A5_A5A5;
        for (int i = 0; i <= hold; i++) begin
            own_v = (e.grant == 2'b01) ? ifu_resp_valid_o : lsu_resp_valid_o;
            oth_v = (e.grant == 2'b01) ? lsu_resp_valid_o : ifu_resp_valid_o;
            own_d = (e.grant == 2'b01) ? ifu_rdata_o : lsu_rdata_o;
            check_val("resp_valid", {63'd0, own_v}, 64'd1);
            check_val("resp_other", {63'd0, oth_v}, 64'd0);
            check_val("resp_rdata", {32'd0, own_d}, {32'd0, e.rdata});
            check_val("resp_ifu_rdy", {63'd0, ifu_req_ready_o}, 64'd0);
            if (i < hold) begin
                @(negedge clk);
            end
        end
        if (e.grant == 2'b01) ifu_resp_ready_i = 1'b1;
        else                  lsu_resp_ready_i = 1'b1;
        @(negedge clk);
        ifu_resp_ready_i = 1'b0;
        lsu_resp_ready_i = 1'b0;
        check_val("idle_grant", {62'd0, grant_o}, 64'd0);
        check_val("idle_resp_v", {62'd0, ifu_resp_valid_o, lsu_resp_valid_o}, 64'd0);
    endtask

    initial begin
        logic [1:0] tie2_win;
        rst              = 1'b0;
        ifu_req_valid_i  = 1'b0;
        ifu_addr_i       = 32'd0;
        ifu_resp_ready_i = 1'b0;
        lsu_req_valid_i  = 1'b0;
        lsu_addr_i       = 32'd0;
        lsu_wen_i        = 1'b0;
        lsu_wdata_i      = 32'd0;
        lsu_wmask_i      = 8'd0;
        lsu_resp_ready_i = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_rdata_i      = 32'd0;

        // Reset state, with both masters requesting during reset.
        repeat (2) @(negedge clk);
        ifu_req_valid_i = 1'b1;
        lsu_req_valid_i = 1'b1;
        #1;
        check_val("rst_req_rdy", {62'd0, ifu_req_ready_o, lsu_req_ready_o}, 64'd0);
        check_val("rst_grant", {62'd0, grant_o}, 64'd0);
        check_val("rst_mem_v", {62'd0, mem_req_valid_o, mem_resp_ready_o}, 64'd0);
        check_val("rst_resp_v", {62'd0, ifu_resp_valid_o, lsu_resp_valid_o}, 64'd0);
        check_val("rst_addr", {32'd0, mem_addr_o}, 64'd0);
        ifu_req_valid_i = 1'b0;
        lsu_req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Two ties in a row.
        drive_req(1'b1, 1'b1, 2'b10, 32'h8000_0010, 32'h8000_0020, 1'b0, 32'd0, 8'h0F, 32'h1111_2222);
        mem_serve(0, 32'h1111_2222, 0);
`ifdef ARB_ROUND_ROBIN_EN
        tie2_win = 2'b01;
`else
        tie2_win = 2'b10;
`endif
        drive_req(1'b1, 1'b1, tie2_win, 32'h8000_0030, 32'h8000_0040, 1'b0, 32'd0, 8'h0F, 32'h3333_4444);
        mem_serve(0, 32'h3333_4444, 0);

        // IFU fetch alone, minimum latency.
        drive_req(1'b1, 1'b0, 2'b01, 32'h8000_0000, 32'd0, 1'b0, 32'd0, 8'h00, 32'h0000_0413);
        mem_serve(0, 32'h0000_0413, 0);

        // LSU store; IFU keeps requesting throughout and must not be accepted.
        drive_req(1'b0, 1'b1, 2'b10, 32'd0, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 8'h0F, 32'd0);
        ifu_req_valid_i = 1'b1;
        ifu_addr_i      = 32'h8000_0004;
        mem_serve(0, 32'h5555_AAAA, 0);
        // The waiting IFU request is accepted on the first IDLE cycle.
        drive_req(1'b1, 1'b0, 2'b01, 32'h8000_0004, 32'd0, 1'b0, 32'd0, 8'h00, 32'h0010_0093);
        // Memory stalls the request for 5 cycles.
        mem_serve(5, 32'h0010_0093, 0);

        // LSU load whose response is held 4 cycles while IFU waits.
        drive_req(1'b0, 1'b1, 2'b10, 32'd0, 32'h8000_0200, 1'b0, 32'd0, 8'h03, 32'hCAFE_F00D);
        ifu_req_valid_i = 1'b1;
        ifu_addr_i      = 32'h8000_0008;
        mem_serve(0, 32'hCAFE_F00D, 4);
        drive_req(1'b1, 1'b0, 2'b01, 32'h8000_0008, 32'd0, 1'b0, 32'd0, 8'h00, 32'h0000_0013);
        mem_serve(0, 32'h0000_0013, 0);

        // Request withdrawn before its handshake: no grant.
        ifu_req_valid_i = 1'b1;
        ifu_addr_i      = 32'h8000_000C;
        #1;
        check_val("drop_ready", {63'd0, ifu_req_ready_o}, 64'd1);
        #2;
        ifu_req_valid_i = 1'b0;
        @(negedge clk);
        check_val("drop_grant", {62'd0, grant_o}, 64'd0);
        check_val("drop_mem_v", {63'd0, mem_req_valid_o}, 64'd0);

        // Reset during WAIT; a late memory response is then ignored.
        ifu_req_valid_i = 1'b1;
        ifu_addr_i      = 32'h8000_0300;
        @(negedge clk);
        ifu_req_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        check_val("mid_wait", {63'd0, mem_resp_ready_o}, 64'd1);
        rst             = 1'b0;
        ifu_req_valid_i = 1'b1;
        @(negedge clk);
        check_val("mrst_grant", {62'd0, grant_o}, 64'd0);
        check_val("mrst_mem_v", {62'd0, mem_req_valid_o, mem_resp_ready_o}, 64'd0);
        check_val("mrst_resp_v", {62'd0, ifu_resp_valid_o, lsu_resp_valid_o}, 64'd0);
        check_val("mrst_req_rdy", {62'd0, ifu_req_ready_o, lsu_req_ready_o}, 64'd0);
        check_val("mrst_addr", {32'd0, mem_addr_o}, 64'd0);
        rst              = 1'b1;
        ifu_req_valid_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_rdata_i      = 32'hBAD0_BAD0;
        #1;
        check_val("late_resp_rdy", {63'd0, mem_resp_ready_o}, 64'd0);
        @(negedge clk);
        mem_resp_valid_i = 1'b0;
        check_val("late_ifu_resp", {63'd0, ifu_resp_valid_o}, 64'd0);
        check_val("late_grant", {62'd0, grant_o}, 64'd0);
        @(negedge clk);
        check_val("late_ifu_resp2", {63'd0, ifu_resp_valid_o}, 64'd0);
        check_val("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
